// File: rtl/gmii_frame_gen.sv
// GMII receive-side frame generator: bursts of preamble/SFD/payload/FCS frames
// separated by a fixed inter-frame gap, with selectable payload pattern.
module gmii_frame_gen #(
  parameter int LEN_W      = 11,
  parameter int IFG_CYCLES = 12,
  parameter int CNT_W      = 16
) (
  input  logic             eth_clocks_rx,
  input  logic             eth_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic             abort,
  output logic             eth_rx_dv,
  output logic [7:0]       eth_rx_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  // state | meaning
  // IDLE  | waiting for an accepted start
  // PRE   | 7 preamble bytes 0x55
  // SFD   | start-of-frame delimiter 0xD5
  // PAY   | len payload bytes from the pattern generator
  // FCS   | 4 CRC-32 bytes, least-significant first
  // IFG   | IFG_CYCLES idle cycles, then next frame or IDLE
  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, FCS, IFG} state_t;

  localparam int CW = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [LEN_W-1:0] len_r;
  logic [CNT_W-1:0] reps_r;
  logic [1:0]       mode_r;
  logic [7:0]       seed_r;
  logic [7:0]       pat;
  logic [7:0]       pat_nxt;
  logic [7:0]       seed_eff;
  logic [31:0]      crc;
  logic [31:0]      crc_nxt;
  logic [23:0]      fcs_sr;
  logic             abort_l;
  logic             accept;
  logic             stop_burst;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    seed_eff = (mode == 2'd2 && seed == 8'h00) ? 8'h01 : seed;
    case (mode_r)
      2'd1:    pat_nxt = pat + 8'd1;
      2'd2:    pat_nxt = {pat[6:0], pat[7] ^ pat[5] ^ pat[4] ^ pat[3]};
      default: pat_nxt = pat;
    endcase
    crc_nxt = crc_upd(crc, pat);
  end

  assign accept     = start && (len != '0) && (reps != '0);
  // frame_cnt already includes the frame just finished when IFG ends
  assign stop_burst = abort_l || abort || (frame_cnt >= reps_r);

  always_ff @(posedge eth_clocks_rx or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      len_r       <= '0;
      reps_r      <= '0;
      mode_r      <= 2'd0;
      seed_r      <= 8'h00;
      pat         <= 8'h00;
      crc         <= CRC_INIT;
      fcs_sr      <= '0;
      abort_l     <= 1'b0;
      eth_rx_dv   <= 1'b0;
      eth_rx_data <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) abort_l <= 1'b1;
      case (state)
        IDLE: begin
          abort_l <= 1'b0;
          if (accept) begin
            len_r       <= len;
            reps_r      <= reps;
            mode_r      <= mode;
            seed_r      <= seed_eff;
            pat         <= seed_eff;
            crc         <= CRC_INIT;
            frame_cnt   <= '0;
            busy        <= 1'b1;
            cnt         <= CW'(6);
            eth_rx_dv   <= 1'b1;
            eth_rx_data <= 8'h55;
            state       <= PRE;
          end
        end
        PRE: begin
          if (cnt == '0) begin
            eth_rx_data <= 8'hD5;
            state       <= SFD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SFD: begin
          cnt         <= CW'(len_r) - 1'b1;
          eth_rx_data <= pat;
          pat         <= pat_nxt;
          crc         <= crc_nxt;
          state       <= PAY;
        end
        PAY: begin
          if (cnt == '0) begin
            // crc already covers the last payload byte loaded one edge earlier
            eth_rx_data <= ~crc[7:0];
            fcs_sr      <= ~crc[31:8];
            cnt         <= CW'(3);
            state       <= FCS;
          end else begin
            cnt         <= cnt - 1'b1;
            eth_rx_data <= pat;
            pat         <= pat_nxt;
            crc         <= crc_nxt;
          end
        end
        FCS: begin
          if (cnt == '0) begin
            eth_rx_dv   <= 1'b0;
            eth_rx_data <= 8'h00;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            cnt         <= CW'(IFG_CYCLES - 1);
            state       <= IFG;
          end else begin
            cnt         <= cnt - 1'b1;
            eth_rx_data <= fcs_sr[7:0];
            fcs_sr      <= fcs_sr >> 8;
          end
        end
        IFG: begin
          if (cnt == '0) begin
            if (stop_burst) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              abort_l <= 1'b0;
              state   <= IDLE;
            end else begin
              pat         <= seed_r;
              crc         <= CRC_INIT;
              cnt         <= CW'(6);
              eth_rx_dv   <= 1'b1;
              eth_rx_data <= 8'h55;
              state       <= PRE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Directed bench for gmii_frame_gen: frame contents, gaps, abort, ignored starts, reset.
module tb_gmii_frame_gen;

  typedef logic [8:0] fq_t[$];

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] len;
  logic [15:0] reps;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic        abort;
  logic        eth_rx_dv;
  logic [7:0]  eth_rx_data;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  gmii_frame_gen #(.LEN_W(11), .IFG_CYCLES(12), .CNT_W(16)) dut (
    .eth_clocks_rx(clk),
    .eth_rst_n(rst_n),
    .start(start),
    .len(len),
    .reps(reps),
    .mode(mode),
    .seed(seed),
    .abort(abort),
    .eth_rx_dv(eth_rx_dv),
    .eth_rx_data(eth_rx_data),
    .busy(busy),
    .done(done),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      if (c[0] ^ d[k]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [7:0] pat_step(input logic [1:0] m, input logic [7:0] p);
    if (m == 2'd1) return p + 8'd1;
    if (m == 2'd2) return {p[6:0], ^(p & 8'hB8)};
    return p;
  endfunction

  function automatic fq_t build_frame(input int l, input logic [1:0] m, input logic [7:0] s);
    fq_t q;
    logic [31:0] c;
    logic [7:0]  p;
    c = 32'hFFFF_FFFF;
    p = (m == 2'd2 && s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < 7; i++) q.push_back(9'h155);
    q.push_back(9'h1D5);
    for (int i = 0; i < l; i++) begin
      q.push_back({1'b1, p});
      c = crc_byte(c, p);
      p = pat_step(m, p);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) q.push_back({1'b1, c[8*i +: 8]});
    return q;
  endfunction

  // Called at the negedge right before the accepting posedge.
  task automatic pulse_start(input logic [10:0] l, input logic [15:0] r,
                             input logic [1:0] m, input logic [7:0] s);
    len = l; reps = r; mode = m; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input fq_t q, input int abort_at, input int start_at);
    foreach (q[i]) begin
      chk($sformatf("%s byte%0d", tag, i), 32'({eth_rx_dv, eth_rx_data}), 32'(q[i]));
      abort = (i == abort_at);
      start = (i == start_at);
      if (i == start_at) begin len = 11'd5; seed = 8'h99; mode = 2'd1; reps = 16'd4; end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic gap(input string tag, input logic last, input logic [15:0] cnt_exp);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s ifg%0d dv/busy/done", tag, i), 32'({eth_rx_dv, eth_rx_data, busy, done}),
          32'({1'b0, 8'h00, 1'b1, 1'b0}));
      @(negedge clk);
    end
    if (last) begin
      chk($sformatf("%s done pulse", tag), 32'({done, busy, eth_rx_dv}), 32'({1'b1, 1'b0, 1'b0}));
      chk($sformatf("%s frame_cnt", tag), 32'(frame_cnt), 32'(cnt_exp));
      @(negedge clk);
      chk($sformatf("%s done low", tag), 32'(done), 32'(0));
    end
  endtask

  task automatic quiet(input string tag, input int n, input logic [15:0] cnt_exp);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s quiet%0d", tag, i), 32'({eth_rx_dv, eth_rx_data, busy, done, frame_cnt}),
          32'({1'b0, 8'h00, 1'b0, 1'b0, cnt_exp}));
      @(negedge clk);
    end
  endtask

  initial begin
    fq_t q;
    rst_n = 1'b1; start = 1'b0; len = '0; reps = '0; mode = '0; seed = '0; abort = 1'b0;

    // Reset asserts asynchronously, before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk("reset outputs", 32'({eth_rx_dv, eth_rx_data, busy, done, frame_cnt}), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Incrementing pattern over "123456789": standard CRC check value.
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(9'h155);
    q.push_back(9'h1D5);
    for (int i = 0; i < 9; i++) q.push_back(9'h131 + 9'(i));
    q.push_back(9'h126); q.push_back(9'h139); q.push_back(9'h1F4); q.push_back(9'h1CB);
    pulse_start(11'd9, 16'd1, 2'd1, 8'h31);
    chk("busy after start", 32'(busy), 32'(1));
    run_frame("f31", q, -1, -1);
    gap("f31", 1'b1, 16'd1);

    // Three constant-pattern frames back to back.
    q = build_frame(4, 2'd0, 8'hAA);
    pulse_start(11'd4, 16'd3, 2'd0, 8'hAA);
    chk("frame_cnt cleared on start", 32'(frame_cnt), 32'(0));
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("rep%0d", f), q, -1, -1);
      gap($sformatf("rep%0d", f), f == 2, 16'd3);
    end

    // Abort mid-payload of a 5-frame burst.
    q = build_frame(6, 2'd1, 8'h10);
    pulse_start(11'd6, 16'd5, 2'd1, 8'h10);
    run_frame("abort", q, 10, -1);
    gap("abort", 1'b1, 16'd1);
    quiet("abort", 30, 16'd1);

    // Start while busy must not disturb the running frame.
    q = build_frame(3, 2'd0, 8'h77);
    pulse_start(11'd3, 16'd1, 2'd0, 8'h77);
    run_frame("busy_start", q, -1, 3);
    gap("busy_start", 1'b1, 16'd1);
    quiet("busy_start", 20, 16'd1);

    // Starts with len=0 or reps=0 are ignored.
    pulse_start(11'd0, 16'd1, 2'd1, 8'h12);
    quiet("len0", 10, 16'd1);
    pulse_start(11'd4, 16'd0, 2'd1, 8'h12);
    quiet("reps0", 10, 16'd1);

    // Reset during payload truncates immediately.
    pulse_start(11'd20, 16'd2, 2'd1, 8'h00);
    repeat (12) @(negedge clk);
    chk("in payload", 32'({eth_rx_dv, eth_rx_data}), 32'({1'b1, 8'h04}));
    #2 rst_n = 1'b0;
    #1 chk("reset mid-frame", 32'({eth_rx_dv, eth_rx_data, busy, done, frame_cnt}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    quiet("post reset", 10, 16'd0);
    q = build_frame(5, 2'd2, 8'h5A);
    pulse_start(11'd5, 16'd1, 2'd2, 8'h5A);
    run_frame("after reset", q, -1, -1);
    gap("after reset", 1'b1, 16'd1);

    // PRBS-8 with zero seed starts from 0x01.
    q = build_frame(64, 2'd2, 8'h00);
    pulse_start(11'd64, 16'd1, 2'd2, 8'h00);
    repeat (8) @(negedge clk);
    chk("prbs first byte", 32'({eth_rx_dv, eth_rx_data}), 32'(9'h101));
    for (int i = 0; i < 8; i++) void'(q.pop_front());
    run_frame("prbs", q, -1, -1);
    gap("prbs", 1'b1, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gmii_frame_gen.md
GMII_FRAME_GEN -- requirements
Module: gmii_frame_gen

Interface
REQ-001 SHALL have parameter LEN_W, default 11, the width of the payload length field (maximum payload 2^LEN_W-1 bytes).
REQ-002 SHALL have parameter IFG_CYCLES, default 12, the inter-frame gap in cycles; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the repeat count and frame counter.
REQ-004 SHALL have port eth_clocks_rx, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port eth_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
REQ-007 SHALL have port len, input, LEN_W bits: payload bytes per frame, sampled on accepted start.
REQ-008 SHALL have port reps, input, CNT_W bits: frames per burst, sampled on accepted start.
REQ-009 SHALL have port mode, input, 2 bits: payload pattern (0 = constant seed, 1 = incrementing from seed, 2 = PRBS-8, 3 = reserved, treated as 0); sampled on accepted start.
REQ-010 SHALL have port seed, input, 8 bits: pattern seed, sampled on accepted start.
REQ-011 SHALL have port abort, input, 1 bit: stops the burst after the current frame.
REQ-012 SHALL have port eth_rx_dv, output, 1 bit: GMII data valid.
REQ-013 SHALL have port eth_rx_data, output, 8 bits: GMII data byte.
REQ-014 SHALL have port busy, output, 1 bit: high from the accepted start until the final IFG ends.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the burst completes.
REQ-016 SHALL have port frame_cnt, output, CNT_W bits: frames fully emitted in the current or last burst.

Function
REQ-017 SHALL accept start only in IDLE with len!=0 and reps!=0; otherwise start is ignored.
REQ-018 SHALL use FSM states IDLE, PRE, SFD, PAY, FCS, IFG.
- IDLE -> PRE on accepted start.
- PRE: 7 cycles.
- SFD: 1 cycle.
- PAY: len cycles.
- FCS: 4 cycles.
- IFG: IFG_CYCLES cycles.
REQ-019 SHALL drive eth_rx_dv=1 during PRE/SFD/PAY/FCS and 0 otherwise; eth_rx_data=0x00 whenever dv=0.
REQ-020 SHALL emit 0x55 in PRE, 0xD5 in SFD, and the pattern in PAY.
- First PAY byte appears on the cycle after the accepted start + 8 cycles (registered outputs; preamble begins the cycle after start).
REQ-021 SHALL generate the pattern per mode.
- Mode 1: increments by 1 per byte, mod 256.
- Mode 2: x^8+x^6+x^5+x^4+1 Fibonacci LFSR; seed 0x00 replaced by 0x01.
- The pattern restarts from seed at every frame.
REQ-022 SHALL compute IEEE 802.3 CRC-32 over PAY bytes only.
- Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
- FCS emitted least-significant byte first.
REQ-023 SHALL increment frame_cnt on the last FCS byte, saturating at all-ones.
REQ-024 SHALL leave IFG for PRE of the next frame if frames emitted < reps and abort has not been seen; otherwise it SHALL return to IDLE and pulse done in the first IDLE cycle.
REQ-025 SHALL latch abort asserted in any non-IDLE state.
- The current frame is completed including FCS and IFG.
- No further frame starts.
- The latch clears in IDLE.
REQ-026 SHALL give abort precedence over the repeat test when both apply in the same cycle.
REQ-027 SHALL clear frame_cnt on accepted start; otherwise it holds its value in IDLE.
REQ-028 SHALL ignore changes on len/reps/mode/seed while busy.

Reset
REQ-029 SHALL, while eth_rst_n=0, immediately force:
- State IDLE.
- eth_rx_dv=0, eth_rx_data=0x00.
- busy=0, done=0, frame_cnt=0.
- Abort latch cleared.
- CRC register 0xFFFFFFFF.
REQ-030 SHALL, on reset mid-frame, truncate the frame with no FCS and no done pulse; the first accepted start after release begins a fresh frame.

Verification
REQ-031 SHALL be verified with start, len=9, mode=1, seed=0x31, reps=1 -> 7x 0x55, 0xD5, 0x31..0x39, then 0x26,0x39,0xF4,0xCB; dv high 21 cycles; done after 12 IFG cycles; frame_cnt=1.
REQ-032 SHALL be verified with reps=3, len=4, mode=0, seed=0xAA -> three identical 16-byte frames, dv low exactly IFG_CYCLES between them; frame_cnt=3.
REQ-033 SHALL be verified with abort pulsed during PAY of frame 1 of reps=5 -> frame 1 completes with a valid FCS, no frame 2, done pulses, frame_cnt=1.
REQ-034 SHALL be verified with start while busy, and with start with len=0 -> both ignored, with no change to outputs.
REQ-035 SHALL be verified with eth_rst_n low during PAY -> dv=0 the same instant; after release, a new start produces a correct frame.
REQ-036 SHALL be verified with mode=2, seed=0x00, len=64 -> first payload byte 0x01, and the sequence matches the reference LFSR model.
